// File: rtl/generator_subchei_if.sv
// generator_subchei_if: key load, subkey stream and status bundle for the IDEA key schedule
interface generator_subchei_if;
  logic         start;
  logic [127:0] key;
  logic         sk_ready;
  logic         sk_valid;
  logic [15:0]  sk_out;
  logic [5:0]   sk_index;
  logic         busy;
  logic         done;
  modport master (input start, key, sk_ready, output sk_valid, sk_out, sk_index, busy, done);
  modport slave  (output start, key, sk_ready, input sk_valid, sk_out, sk_index, busy, done);
endinterface

// File: rtl/generator_subchei.sv
// generator_subchei: IDEA key schedule, streams Z1..Z52 over valid/ready, rotating the key by 25 every 8 subkeys
module generator_subchei #(
  parameter int KEY_W       = 128,
  parameter int SK_W        = 16,
  parameter int NUM_SUBKEYS = 52,
  parameter int ROT         = 25
) (
  input logic clk,
  input logic rst,
  generator_subchei_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] win;
  logic [5:0]       idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      idx     <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        key_reg <= bus.key;
        idx     <= '0;
        state   <= EMIT;
      end
    end else if (state == EMIT) begin
      if (bus.sk_ready) begin
        idx <= idx + 6'd1;
        if (idx[2:0] == 3'd7) key_reg <= {key_reg[KEY_W-ROT-1:0], key_reg[KEY_W-1:KEY_W-ROT]};
        if (idx == 6'(NUM_SUBKEYS - 1)) state <= DONE;
      end
    end else
      state <= IDLE;
  // Shift the selected 16-bit word to the top so the mux is a plain barrel shift
  assign win          = key_reg << {idx[2:0], 4'b0};
  assign bus.sk_out   = win[KEY_W-1 -: SK_W];
  assign bus.sk_index = idx;
  assign bus.sk_valid = state == EMIT;
  assign bus.busy     = state == EMIT;
  assign bus.done     = state == DONE;
endmodule

// File: tb/tb_generator_subchei.sv
// tb_generator_subchei: table vectors, random keys with random backpressure against a rotate-by-25 model
module tb_generator_subchei;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  generator_subchei_if bus();
  generator_subchei dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [15:0] got [52];
  typedef struct {
    logic [127:0] key;
    int           i;
    logic [15:0]  z;
  } vec_t;
  vec_t tbl [$];
  localparam logic [127:0] K2 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] K6 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

  // Subkey i is word (i mod 8) of the user key rotated left by 25 per completed group of 8
  function automatic logic [15:0] model(input logic [127:0] k, input int i);
    int s;
    logic [127:0] r;
    s = (25 * (i / 8)) % 128;
    r = (s == 0) ? k : ((k << s) | (k >> (128 - s)));
    return 16'(r >> (112 - 16 * (i % 8)));
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic expand(input logic [127:0] k, input int pct, input bit inject);
    int n = 0;
    int cyc = 0;
    bit held = 0;
    bit early_done = 0;
    logic [15:0] ho = '0;
    logic [5:0] hi = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.key = k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key = {$urandom, $urandom, $urandom, $urandom};
    check("first_valid", {bus.sk_valid, bus.busy, bus.sk_index}, {1'b1, 1'b1, 6'd0});
    while (n < 52 && cyc < 3000) begin
      if (held) check("stall_hold", {bus.sk_out, bus.sk_index}, {ho, hi});
      if (bus.done) early_done = 1;
      bus.sk_ready = $urandom_range(99) < pct;
      bus.start = inject && ($urandom_range(7) == 0);
      if (bus.start) bus.key = '1;
      if (bus.sk_valid && bus.sk_ready) begin
        check("subkey", {bus.sk_index, bus.sk_out}, {6'(n), model(k, n)});
        got[n] = bus.sk_out;
        n++;
        held = 0;
      end else begin
        held = bus.sk_valid;
        ho = bus.sk_out;
        hi = bus.sk_index;
      end
      cyc++;
      @(negedge clk);
    end
    bus.sk_ready = 1'b0;
    bus.start = 1'b0;
    check("xfer_count", 128'(n), 128'd52);
    check("done_pulse", {bus.done, bus.sk_valid, bus.busy}, 3'b100);
    check("no_early_done", 128'(early_done), 128'd0);
    if (inject) begin
      bus.start = 1'b1;
      bus.key = '1;
      @(negedge clk);
      check("start_in_done_ignored", {bus.done, bus.sk_valid, bus.busy}, 3'b000);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] k2z [24];
    logic [127:0] last;
    int c;
    bit saw;
    k2z = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008,
            16'h0400, 16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00, 16'h1000, 16'h0200,
            16'h0010, 16'h0014, 16'h0018, 16'h001C, 16'h0020, 16'h0004, 16'h0008, 16'h000C};
    for (int i = 0; i < 24; i++) tbl.push_back('{K2, i, k2z[i]});
    tbl.push_back('{K6, 0, 16'h8000});
    tbl.push_back('{K6, 1, 16'h0000});
    tbl.push_back('{K6, 7, 16'h0000});
    tbl.push_back('{K6, 8, 16'h0000});
    tbl.push_back('{K6, 13, 16'h0000});
    tbl.push_back('{K6, 14, 16'h0100});
    tbl.push_back('{K6, 15, 16'h0000});
    tbl.push_back('{K6, 16, 16'h0000});
    tbl.push_back('{K6, 20, 16'h0002});
    bus.start = 1'b0;
    bus.key = '0;
    bus.sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.sk_valid, bus.sk_out, bus.sk_index, bus.busy, bus.done}, '0);
    rst = 1'b0;
    last = '0;
    foreach (tbl[j]) begin
      if (j == 0 || tbl[j].key != last) expand(tbl[j].key, 100, 0);
      last = tbl[j].key;
      check($sformatf("table_z%0d", tbl[j].i + 1), got[tbl[j].i], tbl[j].z);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.key = K2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sk_ready = 1'b1;
    c = 0;
    while (bus.sk_index != 6'd20 && c < 100) begin
      c++;
      @(negedge clk);
    end
    check("reach_idx20", 128'(bus.sk_index), 128'd20);
    rst = 1'b1;
    #1;
    check("mid_reset", {bus.sk_valid, bus.sk_out, bus.sk_index, bus.busy, bus.done}, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.sk_ready = 1'b0;
    saw = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done || bus.sk_valid) saw = 1;
    end
    check("no_done_after_reset", 128'(saw), 128'd0);
    expand(K2, 100, 1);
    for (int r = 0; r < 100; r++)
      expand({$urandom, $urandom, $urandom, $urandom}, 50, r % 4 == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
